shift_normalizer: RTL and testbench

//   Iterative normalizer: the inverse companion of shifter_rotator. Given a 32-bit

---
 rtl/shift_normalizer.sv | 87 ++++++++
 tb/tb_shift_normalizer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts a 32-bit operand one bit per cycle until its MSB (dir=1)
// or LSB (dir=0) is set, then reports the normalized value and the shift count.
module shift_normalizer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic             dir_q;
    logic             target_set;

    assign target_set = dir_q ? work[WIDTH-1] : work[0];

    // NOTE: all state here is sequential, so every assignment is non-blocking to avoid
    // ordering races between registers updated on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            dir_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            count <= '0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= a;
                        dir_q <= dir;
                        count <= '0;
                        zero  <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result is published on entry to DONE so it is valid alongside the pulse.
                    if (work == '0) begin
                        zero  <= 1'b1;
                        count <= '0;
                        out   <= work;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (target_set) begin
                        out   <= work;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        work  <= dir_q ? (work << 1) : (work >> 1);
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed corner cases plus a random round trip
// against a bit-scan reference model.
module tb_shift_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] a = '0;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic [4:0]  count;
    logic        zero;

    int errors = 0;
    int checks = 0;

    shift_normalizer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .dir  (dir),
        .a    (a),
        .busy (busy),
        .done (done),
        .out  (out),
        .count(count),
        .zero (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: locate the first set bit from the target end by scanning bit positions.
    function automatic void model(input logic d, input logic [31:0] v,
                                  output logic [31:0] o, output int n, output logic z);
        z = (v == 32'd0);
        n = 0;
        o = v;
        if (!z) begin
            if (d) begin
                for (int i = 31; i >= 0; i--) if (v[i]) begin n = 31 - i; break; end
                o = v << n;
            end else begin
                for (int i = 0; i < 32; i++) if (v[i]) begin n = i; break; end
                o = v >> n;
            end
        end
    endfunction

    // Issues one operation; optionally pulses a spurious start mid-run and/or during DONE.
    task automatic run_op(input logic d, input logic [31:0] v, input bit mid_start,
                          input bit done_start, input bit roundtrip);
        logic [31:0] exp_out;
        int          exp_n;
        logic        exp_z;
        int          edges;
        logic [31:0] hold_out;
        logic [4:0]  hold_cnt;
        model(d, v, exp_out, exp_n, exp_z);
        @(negedge clk);
        start = 1'b1; dir = d; a = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dir = ~d; a = ~v;
        check($sformatf("accept_busy %h", v), 32'(busy), 32'd1);
        check($sformatf("accept_count %h", v), 32'(count), 32'd0);
        edges = 0;
        while (!done && edges < 40) begin
            if (!done) check($sformatf("busy_mid %h", v), 32'(busy), 32'd1);
            if (mid_start && edges == 3) begin start = 1'b1; a = 32'h1234_5678; end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            edges++;
        end
        check($sformatf("latency %h", v), 32'(edges + 1), 32'(exp_n + 2));
        check($sformatf("busy_done %h", v), 32'(busy), 32'd1);
        check($sformatf("out %h", v), out, exp_out);
        check($sformatf("count %h", v), 32'(count), 32'(exp_n));
        check($sformatf("zero %h", v), 32'(zero), 32'(exp_z));
        if (roundtrip)
            check($sformatf("roundtrip %h", v), d ? (out >> count) : (out << count), v);
        hold_out = out;
        hold_cnt = count;
        if (done_start) begin start = 1'b1; a = 32'hDEAD_BEEF; dir = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check($sformatf("done_pulse %h", v), 32'(done), 32'd0);
        check($sformatf("idle_busy %h", v), 32'(busy), 32'd0);
        if (done_start || mid_start) begin
            check($sformatf("hold_out %h", v), out, hold_out);
            check($sformatf("hold_count %h", v), 32'(count), 32'(hold_cnt));
            repeat (2) @(negedge clk);
            check($sformatf("no_restart %h", v), 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        d;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out", out, 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 32'hF0F0_F000, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op(1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

        // Abort a long operation with an asynchronous reset between clock edges.
        @(negedge clk);
        start = 1'b1; dir = 1'b1; a = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", out, 32'd0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            if ((i % 4) == 1) r = r >> $urandom_range(31, 0);
            if ((i % 4) == 2) r = r << $urandom_range(31, 0);
            if (r == 32'd0) r = 32'd1;
            d = 1'(($urandom) & 1);
            run_op(d, r, 1'b0, 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
